gen_scheduler: RTL

Sequences the life-logic engine and arbitrates board-memory access between generation updates and user cell edits. It converts the UI speed setting into generation requests paced by frame ticks, and starts the engine. When the engine reports done, it flips the double-buffer select. User clicks become read-modify-write toggles of the cell under the cursor, serviced only between generations.

---
 rtl/gen_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gen_scheduler.sv
// gen_scheduler
// Paces life-engine generations from frame ticks / single steps, flips the
// double-buffer select when a generation finishes, and turns user clicks into
// read-modify-write toggles of the cell under the cursor between generations.
//
// Ports
//   clk_in, rst_n_in            clock, async active-low reset
//   frame_tick_in               one pulse per video frame
//   speed_in                    0 = paused, s > 0 = one generation per (2**LOG_MAX_SPEED - s) frames
//   step_in                     single-generation request pulse
//   click_in                    debounced click level; rising edge requests a toggle
//   cursor_x_in, cursor_y_in    cursor cell position
//   logic_start_out             one-cycle engine start
//   logic_done_in               one-cycle engine completion
//   buf_sel_out                 displayed/source buffer; engine writes the other one
//   edit_addr_out               {y, x} of the cell being edited
//   edit_rd_en_out              edit read strobe
//   edit_rd_data_in             cell value, RD_LATENCY cycles after the read strobe
//   edit_wr_en_out              edit write strobe
//   edit_wr_data_out            inverted cell value
//   busy_out                    high whenever not IDLE
//   gen_count_out               completed generations, wrapping
//
// state       | meaning
// ------------+---------------------------------------------
// IDLE        | nothing in flight; edits take priority
// RUN_START   | pulse logic_start_out, consume gen request
// RUN_WAIT    | engine running, waiting for logic_done_in
// SWAP        | flip buffer select, bump generation count
// EDIT_RD     | pulse read of the captured cell
// EDIT_WAIT   | wait out the memory read latency
// EDIT_WR     | write back the inverted cell value

module gen_scheduler #(
  parameter int LOG_BOARD_SIZE = 8,
  parameter int LOG_MAX_SPEED  = 4,
  parameter int RD_LATENCY     = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        frame_tick_in,
  input  logic [LOG_MAX_SPEED-1:0]    speed_in,
  input  logic                        step_in,
  input  logic                        click_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_y_in,
  output logic                        logic_start_out,
  input  logic                        logic_done_in,
  output logic                        buf_sel_out,
  output logic [2*LOG_BOARD_SIZE-1:0] edit_addr_out,
  output logic                        edit_rd_en_out,
  input  logic                        edit_rd_data_in,
  output logic                        edit_wr_en_out,
  output logic                        edit_wr_data_out,
  output logic                        busy_out,
  output logic [15:0]                 gen_count_out
);

  localparam int WAIT_W = $clog2(RD_LATENCY + 1);
  localparam int PER_W  = LOG_MAX_SPEED + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_START, S_RUN_WAIT, S_SWAP, S_EDIT_RD, S_EDIT_WAIT, S_EDIT_WR
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [LOG_MAX_SPEED-1:0]    r_frame_cnt;
  logic                        r_gen_pend;
  logic                        r_edit_pend;
  logic                        r_click_q;
  logic [2*LOG_BOARD_SIZE-1:0] r_edit_addr;
  logic [WAIT_W-1:0]           r_wait_cnt;
  logic                        r_rd_latched;
  logic                        r_buf_sel;
  logic [15:0]                 r_gen_count;

  logic [PER_W-1:0]            w_period;
  logic [PER_W-1:0]            w_cnt_inc;
  logic                        w_fire;
  logic                        w_click_rise;
  logic                        w_rd_valid;

  assign w_period     = PER_W'(2**LOG_MAX_SPEED) - PER_W'(speed_in);
  assign w_cnt_inc    = PER_W'(r_frame_cnt) + PER_W'(1);
  // >= (not ==) so a speed increase that shortens the period mid-count fires on the next tick
  assign w_fire       = frame_tick_in && (speed_in != '0) && (w_cnt_inc >= w_period);
  assign w_click_rise = click_in && !r_click_q;
  // the read data lands in the last EDIT_WAIT cycle
  assign w_rd_valid   = (r_state == S_EDIT_WAIT) && (r_wait_cnt == WAIT_W'(1));

  // state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_edit_pend)     w_next = S_EDIT_RD;
        else if (r_gen_pend) w_next = S_RUN_START;
      end
      S_RUN_START: w_next = S_RUN_WAIT;
      S_RUN_WAIT:  if (logic_done_in) w_next = S_SWAP;
      S_SWAP:      w_next = S_IDLE;
      S_EDIT_RD:   w_next = S_EDIT_WAIT;
      S_EDIT_WAIT: if (w_rd_valid) w_next = S_EDIT_WR;
      S_EDIT_WR:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    logic_start_out  = 1'b0;
    edit_rd_en_out   = 1'b0;
    edit_wr_en_out   = 1'b0;
    edit_wr_data_out = 1'b0;
    busy_out         = (r_state != S_IDLE);
    case (r_state)
      S_RUN_START: logic_start_out = 1'b1;
      S_EDIT_RD:   edit_rd_en_out  = 1'b1;
      S_EDIT_WR: begin
        edit_wr_en_out   = 1'b1;
        edit_wr_data_out = ~r_rd_latched;
      end
      default: ;
    endcase
  end

  // request capture, frame pacing and datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frame_cnt  <= '0;
      r_gen_pend   <= 1'b0;
      r_edit_pend  <= 1'b0;
      r_click_q    <= 1'b0;
      r_edit_addr  <= '0;
      r_wait_cnt   <= '0;
      r_rd_latched <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_gen_count  <= '0;
    end else begin
      r_click_q <= click_in;

      if (speed_in == '0)  r_frame_cnt <= '0;
      else if (w_fire)     r_frame_cnt <= '0;
      else if (frame_tick_in) r_frame_cnt <= r_frame_cnt + 1'b1;

      // a new request in the consuming cycle is kept rather than lost
      if (w_fire || step_in)             r_gen_pend <= 1'b1;
      else if (r_state == S_RUN_START)   r_gen_pend <= 1'b0;

      // edit_pend holds the address stable until the write-back completes
      if (w_click_rise && !r_edit_pend) begin
        r_edit_pend <= 1'b1;
        r_edit_addr <= {cursor_y_in, cursor_x_in};
      end else if (r_state == S_EDIT_WR) begin
        r_edit_pend <= 1'b0;
      end

      if (r_state == S_EDIT_RD)        r_wait_cnt <= WAIT_W'(RD_LATENCY);
      else if (r_state == S_EDIT_WAIT) r_wait_cnt <= r_wait_cnt - 1'b1;

      if (w_rd_valid) r_rd_latched <= edit_rd_data_in;

      if (r_state == S_SWAP) begin
        r_buf_sel   <= ~r_buf_sel;
        r_gen_count <= r_gen_count + 16'd1;
      end
    end
  end

  assign buf_sel_out   = r_buf_sel;
  assign gen_count_out = r_gen_count;
  assign edit_addr_out = r_edit_addr;

endmodule
